// File: rtl/ahb_arb_defs_pkg.sv
// Shared encodings for the AHB requester arbiter: HTRANS codes, FSM states and
// the owner-index width helper.
package ahb_arb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // At least one bit so a two-requester build still has a real index.
  function automatic int unsigned owner_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
// Produces both a one-hot grant and its index.
module ahb_rr_arbiter
  import ahb_arb_defs::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = owner_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cidx;

  // ptr is always below NUM_REQ, so a single subtraction wraps the candidate and
  // indices beyond NUM_REQ-1 can never be produced.
  always_comb begin
    any     = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = i + 32'(ptr);
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = IDX_W'(cand);
      if (!any && req[cidx]) begin
        any          = 1'b1;
        gnt_oh[cidx] = 1'b1;
        gnt_idx      = cidx;
      end
    end
  end

endmodule

// File: rtl/ahb_apb_req_arbiter.sv
// Round-robin sharing of one AHB-Lite master port between NUM_REQ requesters, one
// transfer in flight. Optional data-phase watchdog enabled by ARB_TIMEOUT_EN.
module ahb_apb_req_arbiter
  import ahb_arb_defs::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*3-1:0]          req_size,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          hsel,
  output logic [1:0]                    htrans,
  output logic                          hwrite,
  output logic [2:0]                    hsize,
  output logic [ADDR_WIDTH-1:0]         haddr,
  output logic [DATA_WIDTH-1:0]         hwdata,
  input  logic [DATA_WIDTH-1:0]         hrdata,
  input  logic                          hready
);

  localparam int unsigned IDX_W = owner_width(NUM_REQ);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       owner_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     done_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   hsel_q;
  logic [1:0]             htrans_q;
  logic                   hwrite_q;
  logic [2:0]             hsize_q;
  logic [ADDR_WIDTH-1:0]  haddr_q;
  logic [DATA_WIDTH-1:0]  hwdata_q;

  logic                   sel_any;
  logic [NUM_REQ-1:0]     sel_oh;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_write;
  logic [2:0]             sel_size;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [NUM_REQ-1:0]     owner_oh;
  logic [IDX_W-1:0]       ptr_nxt;
  logic                   tmo_hit;

  ahb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .any     (sel_any),
    .gnt_oh  (sel_oh),
    .gnt_idx (sel_idx)
  );

  // One-hot AND-OR mux of the winning requester's command fields.
  always_comb begin
    sel_write = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_write = req_write[i];
        sel_size  = req_size[i*3 +: 3];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign ptr_nxt  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;

  // Counter holds the number of DATA cycles already completed with hready low.
  assign tmo_hit = (state_q == ST_DATA) && !hready &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state_q == ST_ADDR) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_DATA) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
  assign tmo_hit        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      hsel_q   <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          // hready low here means the bridge is still busy; issue nothing.
          if (sel_any && hready) begin
            owner_q  <= sel_idx;
            gnt_q    <= sel_oh;
            hsel_q   <= 1'b1;
            htrans_q <= HTRANS_NONSEQ;
            hwrite_q <= sel_write;
            hsize_q  <= sel_size;
            haddr_q  <= sel_addr;
            wdata_q  <= sel_wdata;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          hsel_q   <= 1'b0;
          htrans_q <= HTRANS_IDLE;
          if (hwrite_q) hwdata_q <= wdata_q;
          state_q  <= ST_DATA;
        end
        ST_DATA: begin
          if (hready || tmo_hit) begin
            if (hready && !hwrite_q) rdata_q <= hrdata;
            done_q  <= owner_oh;
            ptr_q   <= ptr_nxt;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign hsel   = hsel_q;
  assign htrans = htrans_q;
  assign hwrite = hwrite_q;
  assign hsize  = hsize_q;
  assign haddr  = haddr_q;
  assign hwdata = hwdata_q;

  a_gnt_onehot: assert property (@(posedge hclk) disable iff (!hresetn) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge hclk) disable iff (!hresetn) $onehot0(done));
  a_htrans_legal: assert property (@(posedge hclk) disable iff (!hresetn)
                                   (htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ));

endmodule

// File: tb/tb_ahb_apb_req_arbiter.sv
// Scoreboard bench for ahb_apb_req_arbiter with three requesters and a scripted
// bridge model; the timeout case is built only when ARB_TIMEOUT_EN is defined.
module tb_ahb_apb_req_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 64;
`endif

  logic             hclk;
  logic             hresetn;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_write;
  logic [NR*3-1:0]  req_size;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic             err;
  logic [DW-1:0]    rdata;
  logic             hsel;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [AW-1:0]    haddr;
  logic [DW-1:0]    hwdata;
  logic [DW-1:0]    hrdata;
  logic             hready;

  ahb_apb_req_arbiter #(
    .NUM_REQ     (NR),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .req       (req),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .hsel      (hsel),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready)
  );

  typedef struct {
    int          owner;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        err;
  } exp_t;

  typedef struct {
    int          wait_cyc;
    logic [31:0] rdata;
  } br_t;

  exp_t        exp_q[$];
  br_t         br_q[$];
  exp_t        cur;
  br_t         br_cur;
  int          total;
  int          bad;
  int          cycle;
  int          addr_cyc;
  bit          inflight;
  logic        hready_at_edge;
  logic [31:0] model_rdata;
  logic [NR-1:0] oh_tmp;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // rd is the bridge's hrdata for this transfer; the expected rdata output is the
  // last successfully read value, since rdata holds across writes and aborts.
  task automatic push(input int owner, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input int wt, input int lat, input logic er);
    exp_t e;
    br_t  b;
    if (!wr && !er) model_rdata = rd;
    e.owner = owner; e.wr = wr; e.sz = sz; e.addr = a; e.wdata = wd;
    e.rdata = model_rdata; e.lat = lat; e.err = er;
    b.wait_cyc = wt; b.rdata = rd;
    exp_q.push_back(e);
    br_q.push_back(b);
  endtask

  task automatic issue(input int idx, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    req_write[idx]          = wr;
    req_size[idx*3 +: 3]    = sz;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = wd;
    req[idx]                = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge hclk);
      if (gnt[idx]) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("gnt_wait_req%0d", idx), got, 1);
    req[idx] = 1'b0;
    // Scramble fields after grant; the transfer must use the latched copy.
    req_write[idx]          = ~wr;
    req_size[idx*3 +: 3]    = ~sz;
    req_addr[idx*AW +: AW]  = ~a;
    req_wdata[idx*DW +: DW] = ~wd;
  endtask

  task automatic drain();
    for (int n = 0; n < 400; n++) begin
      if (exp_q.size() == 0 && !inflight) break;
      @(negedge hclk);
    end
    check("drain_pending", exp_q.size() + int'(inflight), 0);
    @(negedge hclk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_hsel"}, hsel, 0);
    check({tag, "_htrans"}, htrans, 0);
    check({tag, "_hwrite"}, hwrite, 0);
    check({tag, "_hsize"}, hsize, 0);
    check({tag, "_haddr"}, haddr, 0);
    check({tag, "_hwdata"}, hwdata, 0);
  endtask

  always @(posedge hclk) hready_at_edge = hready;

  // Bridge model: per transfer, hready low for wait_cyc DATA cycles, then high.
  initial begin
    forever begin
      @(negedge hclk);
      if (hresetn && hsel && htrans == 2'b10) begin
        if (br_q.size() == 0) begin
          br_cur.wait_cyc = 0;
          br_cur.rdata    = '0;
        end else begin
          br_cur = br_q.pop_front();
        end
        hrdata = br_cur.rdata;
        hready = 1'b1;
        for (int i = 1; i <= br_cur.wait_cyc + 1; i++) begin
          @(negedge hclk);
          if (!hresetn) begin
            hready = 1'b1;
            break;
          end
          hready = (i == br_cur.wait_cyc + 1);
        end
      end
    end
  end

  // Monitor: pops the expectation at each NONSEQ and checks completion on done.
  initial begin
    forever begin
      @(negedge hclk);
      cycle++;
      if (!hresetn) begin
        inflight = 1'b0;
      end else begin
        if (done != '0) begin
          if (!inflight) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=%b, required none", done);
          end else begin
            oh_tmp = '0;
            oh_tmp[cur.owner] = 1'b1;
            check("done_owner", done, oh_tmp);
            check("done_latency", cycle - addr_cyc, cur.lat);
            check("done_err", err, cur.err);
            check("done_rdata", rdata, cur.rdata);
            inflight = 1'b0;
          end
        end
        if (hsel && htrans == 2'b10) begin
          check("nonseq_while_busy", inflight, 0);
          check("grant_saw_hready", hready_at_edge, 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_nonseq: got haddr=0x%0h, required no transfer", haddr);
          end else begin
            cur = exp_q.pop_front();
            oh_tmp = '0;
            oh_tmp[cur.owner] = 1'b1;
            check("addr_gnt", gnt, oh_tmp);
            check("addr_haddr", haddr, cur.addr);
            check("addr_hwrite", hwrite, cur.wr);
            check("addr_hsize", hsize, cur.sz);
            inflight = 1'b1;
            addr_cyc = cycle;
          end
        end else if (inflight && cycle == addr_cyc + 1) begin
          check("data_htrans", htrans, 0);
          check("data_hsel", hsel, 0);
          check("data_haddr", haddr, cur.addr);
          if (cur.wr) check("data_hwdata", hwdata, cur.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    total = 0; bad = 0; cycle = 0; addr_cyc = 0; inflight = 1'b0;
    model_rdata = '0;
    hresetn = 1'b0; req = '0; req_write = '0; req_size = '0; req_addr = '0;
    req_wdata = '0; hrdata = '0; hready = 1'b1;
    repeat (2) @(negedge hclk);
    check_zero("reset");
    hresetn = 1'b1;
    @(negedge hclk);

    // Single write from req0.
    push(0, 1'b1, 3'b010, 32'h4000_0010, 32'hA5A5_0001, 32'h0, 0, 2, 1'b0);
    issue(0, 1'b1, 3'b010, 32'h4000_0010, 32'hA5A5_0001);
    drain();

    // Single read from req1.
    push(1, 1'b0, 3'b010, 32'h4000_0004, 32'h0, 32'h1234_5678, 0, 2, 1'b0);
    issue(1, 1'b0, 3'b010, 32'h4000_0004, 32'h0);
    drain();

    // req0/req1 contend for 4 transfers each; pointer is at 2 so req0 wins first.
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b1, (k % 2 == 0) ? 3'b000 : 3'b001, 32'h4000_0100 + 32'(k * 4),
           32'h0000_0A00 + 32'(k), 32'h0, (2 * k) % 3, (2 * k) % 3 + 2, 1'b0);
      push(1, 1'b0, 3'b010, 32'h4000_0200 + 32'(k * 4), 32'h0,
           32'hBEEF_0000 + 32'(k), (2 * k + 1) % 3, (2 * k + 1) % 3 + 2, 1'b0);
    end
    fork
      begin
        for (int k = 0; k < 4; k++)
          issue(0, 1'b1, (k % 2 == 0) ? 3'b000 : 3'b001, 32'h4000_0100 + 32'(k * 4),
                32'h0000_0A00 + 32'(k));
      end
      begin
        for (int k = 0; k < 4; k++)
          issue(1, 1'b0, 3'b010, 32'h4000_0200 + 32'(k * 4), 32'h0);
      end
    join
    drain();

    // Five hready wait states; req1 raised and withdrawn while busy is never served.
    push(0, 1'b1, 3'b010, 32'h4000_0020, 32'h5A5A_0004, 32'h0, 5, 7, 1'b0);
    issue(0, 1'b1, 3'b010, 32'h4000_0020, 32'h5A5A_0004);
    @(negedge hclk);
    req[1] = 1'b1;
    @(negedge hclk);
    req[1] = 1'b0;
    drain();

    // Asynchronous reset during DATA of a req2 read: outputs clear, no done.
    push(2, 1'b0, 3'b010, 32'h4000_0030, 32'h0, 32'h0BAD_0BAD, 10, 12, 1'b0);
    issue(2, 1'b0, 3'b010, 32'h4000_0030, 32'h0);
    repeat (3) @(negedge hclk);
    #2 hresetn = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    model_rdata = '0;
    @(negedge hclk);

    // Pointer back at 0: req1 beats req2, then req2 alone is served and wraps.
    push(1, 1'b0, 3'b010, 32'h4000_0008, 32'h0, 32'h1111_0001, 1, 3, 1'b0);
    push(2, 1'b0, 3'b001, 32'h4000_000C, 32'h0, 32'h2222_0002, 0, 2, 1'b0);
    fork
      issue(1, 1'b0, 3'b010, 32'h4000_0008, 32'h0);
      issue(2, 1'b0, 3'b001, 32'h4000_000C, 32'h0);
    join
    drain();
    push(2, 1'b1, 3'b001, 32'h4000_0040, 32'h3333_0003, 32'h0, 1, 3, 1'b0);
    issue(2, 1'b1, 3'b001, 32'h4000_0040, 32'h3333_0003);
    drain();

`ifdef ARB_TIMEOUT_EN
    // hready stuck low 12 DATA-relative cycles: abort after 8, then req1 waits.
    push(0, 1'b0, 3'b010, 32'h4000_0050, 32'h0, 32'hDEAD_0000, 12, 9, 1'b1);
    push(1, 1'b1, 3'b010, 32'h4000_0054, 32'h4444_0005, 32'h0, 0, 2, 1'b0);
    fork
      issue(0, 1'b0, 3'b010, 32'h4000_0050, 32'h0);
      issue(1, 1'b1, 3'b010, 32'h4000_0054, 32'h4444_0005);
    join
    drain();
`endif

    repeat (3) @(negedge hclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
